// File: rtl/beehive_vr_pkg.sv
// rtl/beehive_vr_pkg.sv - shared VR message types, field geometry and commit engine states
package beehive_vr_pkg;

    localparam int VR_VIEW_W      = 64;
    localparam int VR_OPNUM_W     = 64;
    // Field offsets are counted in bits down from the MSB of the first payload word
    localparam int VR_VIEW_OFF    = 0;
    localparam int VR_OPNUM_OFF   = VR_VIEW_OFF + VR_VIEW_W;
    localparam int VR_HDR_BYTES   = (VR_VIEW_W + VR_OPNUM_W) / 8;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_info;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_UPD    = 3'd4
    } commit_state_e;

endpackage

// File: rtl/commit_eng.sv
// rtl/commit_eng.sv - validates VR commit messages and advances the replica commit opnum
module commit_eng
    import beehive_vr_pkg::*;
#(
    parameter int NOC_DATA_W     = 512,
    parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
    parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      commit_msg_val,
    input  udp_info                   commit_pkt_info,
    output logic                      commit_msg_rdy,

    input  logic                      commit_req_val,
    input  logic [NOC_DATA_W-1:0]     commit_req,
    input  logic                      commit_req_last,
    input  logic [NOC_PADBYTES_W-1:0] commit_req_padbytes,
    output logic                      commit_req_rdy,

    input  logic [63:0]               cur_view,
    input  logic                      status_normal,

    output logic                      commit_upd_val,
    output logic [63:0]               commit_upd_opnum,
    input  logic                      commit_upd_rdy,

    output logic [63:0]               last_commit_opnum,
    output logic                      commit_eng_rdy,
    output logic [31:0]               applied_cnt,
    output logic [31:0]               drop_cnt
);

    commit_state_e state, state_next;

    logic [15:0]           data_length_r;
    logic [VR_VIEW_W-1:0]  view_r;
    logic [VR_OPNUM_W-1:0] opnum_r;

    logic msg_hs;
    logic req_hs;
    logic upd_hs;
    logic accept;

    logic [VR_VIEW_W-1:0]  req_view;
    logic [VR_OPNUM_W-1:0] req_opnum;

    assign req_view  = commit_req[NOC_DATA_W-1-VR_VIEW_OFF -: VR_VIEW_W];
    assign req_opnum = commit_req[NOC_DATA_W-1-VR_OPNUM_OFF -: VR_OPNUM_W];

    // Ready/valid outputs are gated by rst_n so they read 0 while reset is held
    assign commit_msg_rdy   = rst_n && (state == ST_IDLE);
    assign commit_eng_rdy   = rst_n && (state == ST_IDLE);
    assign commit_req_rdy   = rst_n && ((state == ST_HDR) || (state == ST_DRAIN));
    assign commit_upd_val   = rst_n && (state == ST_UPD);
    assign commit_upd_opnum = opnum_r;

    assign msg_hs = commit_msg_val && commit_msg_rdy;
    assign req_hs = commit_req_val && commit_req_rdy;
    assign upd_hs = commit_upd_val && commit_upd_rdy;

    // Equal opnum is a duplicate commit and must not be re-applied
    assign accept = (data_length_r >= 16'(VR_HDR_BYTES))
                 && status_normal
                 && (view_r == cur_view)
                 && (opnum_r > last_commit_opnum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (msg_hs) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (req_hs) begin
                    state_next = commit_req_last ? ST_DECIDE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (req_hs && commit_req_last) begin
                    state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_next = accept ? ST_UPD : ST_IDLE;
            end
            ST_UPD: begin
                if (upd_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_length_r <= '0;
            view_r        <= '0;
            opnum_r       <= '0;
        end else begin
            if (msg_hs) begin
                data_length_r <= commit_pkt_info.data_length;
            end
            if ((state == ST_HDR) && req_hs) begin
                view_r  <= req_view;
                opnum_r <= req_opnum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_commit_opnum <= '0;
            applied_cnt       <= '0;
            drop_cnt          <= '0;
        end else begin
            if ((state == ST_DECIDE) && !accept) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (upd_hs) begin
                last_commit_opnum <= opnum_r;
                applied_cnt       <= applied_cnt + 32'd1;
            end
        end
    end

    // Address, port and padding metadata are carried on the interface but not needed here
    logic unused_inputs;
    assign unused_inputs = ^{commit_req_padbytes, commit_pkt_info.src_ip,
                             commit_pkt_info.dst_ip, commit_pkt_info.src_port,
                             commit_pkt_info.dst_port, commit_req};

endmodule

// File: tb/tb_commit_eng.sv
// tb/tb_commit_eng.sv - table-driven check of commit_eng accept/drop decisions, stalls and reset
module tb_commit_eng;
    import beehive_vr_pkg::*;

    localparam int W  = 128;
    localparam int PB = W / 8;
    localparam int PW = $clog2(PB);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          commit_msg_val;
    udp_info       commit_pkt_info;
    logic          commit_msg_rdy;
    logic          commit_req_val;
    logic [W-1:0]  commit_req;
    logic          commit_req_last;
    logic [PW-1:0] commit_req_padbytes;
    logic          commit_req_rdy;
    logic [63:0]   cur_view;
    logic          status_normal;
    logic          commit_upd_val;
    logic [63:0]   commit_upd_opnum;
    logic          commit_upd_rdy;
    logic [63:0]   last_commit_opnum;
    logic          commit_eng_rdy;
    logic [31:0]   applied_cnt;
    logic [31:0]   drop_cnt;

    commit_eng #(.NOC_DATA_W(W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .commit_msg_val      (commit_msg_val),
        .commit_pkt_info     (commit_pkt_info),
        .commit_msg_rdy      (commit_msg_rdy),
        .commit_req_val      (commit_req_val),
        .commit_req          (commit_req),
        .commit_req_last     (commit_req_last),
        .commit_req_padbytes (commit_req_padbytes),
        .commit_req_rdy      (commit_req_rdy),
        .cur_view            (cur_view),
        .status_normal       (status_normal),
        .commit_upd_val      (commit_upd_val),
        .commit_upd_opnum    (commit_upd_opnum),
        .commit_upd_rdy      (commit_upd_rdy),
        .last_commit_opnum   (last_commit_opnum),
        .commit_eng_rdy      (commit_eng_rdy),
        .applied_cnt         (applied_cnt),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] cv;
        bit          sn;
        logic [63:0] view;
        logic [63:0] opnum;
        logic [15:0] len;
        int          nwords;
        bit          gaps;
        int          stall;
        bit          disturb;
        bit          exp_acc;
        logic [63:0] exp_last;
        logic [31:0] exp_app;
        logic [31:0] exp_drop;
    } vec_t;

    task automatic run_msg(input logic [63:0] v, input logic [63:0] op, input logic [15:0] len,
                           input int nwords, input bit gaps, input int stall, input bit disturb,
                           output bit acc, output int lat);
        int  n;
        int  c_pre;
        bit  done;
        acc = 1'b0;
        lat = -1;
        @(negedge clk);
        commit_pkt_info             = '0;
        commit_pkt_info.data_length = len;
        commit_msg_val              = 1'b1;
        n = 0;
        while (!commit_msg_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!commit_msg_rdy) begin
            chk("msg_rdy_timeout", 0, 1);
            commit_msg_val = 1'b0;
            return;
        end
        c_pre = cyc;
        @(negedge clk);
        commit_msg_val = 1'b0;
        chk("msg_rdy_busy", commit_msg_rdy, 0);
        for (int w = 0; w < nwords; w++) begin
            commit_req_val = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            commit_req_val      = 1'b1;
            commit_req          = (w == 0) ? {v, op} : {$urandom, $urandom, $urandom, $urandom};
            commit_req_last     = (w == nwords - 1);
            commit_req_padbytes = (w == nwords - 1) ? PW'(3) : '0;
            n = 0;
            while (!commit_req_rdy && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!commit_req_rdy) chk("req_rdy_timeout", 0, 1);
            @(negedge clk);
        end
        commit_req_val  = 1'b0;
        commit_req_last = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done && n < 10) begin
            if (commit_upd_val) begin
                acc  = 1'b1;
                done = 1'b1;
            end else if (commit_eng_rdy) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!done) chk("decide_timeout", 0, 1);
        if (acc) begin
            lat = cyc - c_pre;
            chk("upd_opnum", commit_upd_opnum, op);
            for (int s = 0; s < stall; s++) begin
                if (disturb && s == 0) begin
                    status_normal = 1'b0;
                    cur_view      = cur_view + 64'd1;
                end
                @(negedge clk);
                chk("stall_upd_val", commit_upd_val, 1);
                chk("stall_upd_opnum", commit_upd_opnum, op);
                chk("stall_eng_rdy", commit_eng_rdy, 0);
            end
            commit_upd_rdy = 1'b1;
            @(negedge clk);
            commit_upd_rdy = 1'b0;
            chk("post_upd_idle", commit_eng_rdy, 1);
            chk("post_upd_val", commit_upd_val, 0);
        end
    endtask

    vec_t vecs[12];
    bit   acc;
    int   lat;

    initial begin
        rst_n               = 1'b0;
        commit_msg_val      = 1'b0;
        commit_pkt_info     = '0;
        commit_req_val      = 1'b0;
        commit_req          = '0;
        commit_req_last     = 1'b0;
        commit_req_padbytes = '0;
        cur_view            = 64'd5;
        status_normal       = 1'b1;
        commit_upd_rdy      = 1'b0;

        //          cv  sn view opnum                  len nw g st d  acc last                   app drop
        vecs[0]  = '{5, 1, 5, 10,                      16, 1, 0, 0, 0, 1, 10,                    1,  0};
        vecs[1]  = '{5, 1, 5, 12,                      16, 1, 0, 0, 0, 1, 12,                    2,  0};
        vecs[2]  = '{5, 1, 4, 13,                      16, 1, 0, 0, 0, 0, 12,                    2,  1};
        vecs[3]  = '{5, 1, 5, 12,                      16, 1, 0, 0, 0, 0, 12,                    2,  2};
        vecs[4]  = '{5, 1, 5, 11,                      16, 1, 0, 0, 0, 0, 12,                    2,  3};
        vecs[5]  = '{5, 1, 5, 13,                      15, 1, 0, 0, 0, 0, 12,                    2,  4};
        vecs[6]  = '{5, 0, 5, 13,                      16, 1, 0, 0, 0, 0, 12,                    2,  5};
        vecs[7]  = '{5, 1, 5, 13,                      48, 3, 1, 5, 0, 1, 13,                    3,  5};
        vecs[8]  = '{5, 1, 6, 14,                      32, 2, 1, 0, 0, 0, 13,                    3,  6};
        vecs[9]  = '{5, 1, 5, 14,                      16, 1, 0, 3, 1, 1, 14,                    4,  6};
        vecs[10] = '{5, 1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64, 4, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5, 6};
        vecs[11] = '{5, 1, 5, 64'h8000_0000_0000_0000, 16, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 7};

        #1;
        chk("rst_msg_rdy", commit_msg_rdy, 0);
        chk("rst_req_rdy", commit_req_rdy, 0);
        chk("rst_upd_val", commit_upd_val, 0);
        chk("rst_eng_rdy", commit_eng_rdy, 0);
        chk("rst_last", last_commit_opnum, 0);
        chk("rst_applied", applied_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_msg_rdy", commit_msg_rdy, 1);

        // Payload offered while idle must not be consumed
        @(negedge clk);
        commit_req_val  = 1'b1;
        commit_req_last = 1'b1;
        repeat (3) begin
            chk("idle_req_rdy", commit_req_rdy, 0);
            @(negedge clk);
        end
        chk("idle_eng_rdy", commit_eng_rdy, 1);
        commit_req_val  = 1'b0;
        commit_req_last = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cur_view      = vecs[i].cv;
            status_normal = vecs[i].sn;
            run_msg(vecs[i].view, vecs[i].opnum, vecs[i].len, vecs[i].nwords, vecs[i].gaps,
                    vecs[i].stall, vecs[i].disturb, acc, lat);
            chk($sformatf("v%0d_accept", i), 64'(acc), 64'(vecs[i].exp_acc));
            chk($sformatf("v%0d_last", i), last_commit_opnum, vecs[i].exp_last);
            chk($sformatf("v%0d_applied", i), 64'(applied_cnt), 64'(vecs[i].exp_app));
            chk($sformatf("v%0d_drop", i), 64'(drop_cnt), 64'(vecs[i].exp_drop));
            if (vecs[i].exp_acc && vecs[i].nwords == 1 && !vecs[i].gaps)
                chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
        end

        // Reset asserted while draining a multi-word payload
        cur_view      = 64'd5;
        status_normal = 1'b1;
        @(negedge clk);
        commit_pkt_info             = '0;
        commit_pkt_info.data_length = 16'd32;
        commit_msg_val              = 1'b1;
        @(negedge clk);
        commit_msg_val  = 1'b0;
        commit_req_val  = 1'b1;
        commit_req      = {64'd5, 64'd20};
        commit_req_last = 1'b0;
        @(negedge clk);
        chk("drain_req_rdy", commit_req_rdy, 1);
        chk("drain_eng_rdy", commit_eng_rdy, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_msg_rdy", commit_msg_rdy, 0);
        chk("mid_rst_req_rdy", commit_req_rdy, 0);
        chk("mid_rst_upd_val", commit_upd_val, 0);
        chk("mid_rst_eng_rdy", commit_eng_rdy, 0);
        chk("mid_rst_last", last_commit_opnum, 0);
        chk("mid_rst_applied", applied_cnt, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        commit_req_val = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_first_msg_rdy", commit_msg_rdy, 1);
        run_msg(64'd5, 64'd3, 16'd16, 1, 1'b0, 0, 1'b0, acc, lat);
        chk("after_rst_accept", 64'(acc), 1);
        chk("after_rst_latency", 64'(lat), 3);
        chk("after_rst_last", last_commit_opnum, 3);
        chk("after_rst_applied", 64'(applied_cnt), 1);
        chk("after_rst_drop", 64'(drop_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
